// File: rtl/bitcnt_pkg.sv
// rtl/bitcnt_pkg.sv - shared func encodings, FSM states and result width for bitcnt_sched
package bitcnt_pkg;

  localparam int RES_W = 8;

  localparam logic [2:0] FUNC_CLZ_64 = 3'b000;
  localparam logic [2:0] FUNC_CLZ_32 = 3'b001;
  localparam logic [2:0] FUNC_CTZ_64 = 3'b010;
  localparam logic [2:0] FUNC_CTZ_32 = 3'b011;
  localparam logic [2:0] FUNC_CNT_64 = 3'b100;
  localparam logic [2:0] FUNC_CNT_32 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes 11x carry no operation.
  function automatic logic func_illegal(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

endpackage

// File: rtl/bitcnt.sv
// rtl/bitcnt.sv - combinational leading/trailing zero count and population count
module bitcnt
  import bitcnt_pkg::*;
(
  input  logic [63:0]      i_data,
  input  logic [2:0]       i_func,
  output logic [RES_W-1:0] o_count
);

  logic [RES_W-1:0] w_clz64, w_clz32, w_ctz64, w_ctz32, w_pop64, w_pop32;

  // Later loop iterations override earlier ones, so the last hit is the one that sticks.
  always_comb begin
    w_clz64 = 8'd64;
    w_clz32 = 8'd32;
    w_ctz64 = 8'd64;
    w_ctz32 = 8'd32;
    w_pop64 = '0;
    w_pop32 = '0;
    for (int i = 0; i < 64; i++) if (i_data[i]) w_clz64 = 8'(63 - i);
    for (int i = 63; i >= 0; i--) if (i_data[i]) w_ctz64 = 8'(i);
    for (int i = 0; i < 32; i++) if (i_data[i]) w_clz32 = 8'(31 - i);
    for (int i = 31; i >= 0; i--) if (i_data[i]) w_ctz32 = 8'(i);
    for (int i = 0; i < 64; i++) w_pop64 = w_pop64 + {7'd0, i_data[i]};
    for (int i = 0; i < 32; i++) w_pop32 = w_pop32 + {7'd0, i_data[i]};
  end

  always_comb begin
    o_count = '0;
    case (i_func)
      FUNC_CLZ_64: o_count = w_clz64;
      FUNC_CLZ_32: o_count = w_clz32;
      FUNC_CTZ_64: o_count = w_ctz64;
      FUNC_CTZ_32: o_count = w_ctz32;
      FUNC_CNT_64: o_count = w_pop64;
      FUNC_CNT_32: o_count = w_pop32;
      default:     o_count = '0;
    endcase
  end

endmodule

// File: rtl/bitcnt_sched.sv
// rtl/bitcnt_sched.sv - two-requester scheduler sharing one bitcnt datapath
module bitcnt_sched
  import bitcnt_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_data,
  input  logic [2:0]  req0_func,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_data,
  input  logic [2:0]  req1_func,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,
  output logic        rsp1_err,
  output logic        busy
);

  state_t           r_state, w_next_state;
  logic             r_ptr;
  logic             r_owner;
  logic [63:0]      r_data;
  logic [2:0]       r_func;
  logic [63:0]      r_result;
  logic             r_err;
  logic             w_grant_any, w_grant_id, w_accept, w_rsp_live, w_rsp_take;
  logic [RES_W-1:0] w_count;

  always_comb begin
    w_grant_any = req0_valid | req1_valid;
    w_grant_id  = 1'b0;
    if (FAIR != 0) begin
      if (req0_valid && req1_valid) w_grant_id = ~r_ptr;
      else                          w_grant_id = req1_valid;
    end else begin
      w_grant_id = ~req0_valid;
    end
  end

  // Gating with rst_n keeps ready low while reset is held, even though IDLE is already forced.
  assign w_accept   = (r_state == ST_IDLE) & w_grant_any & rst_n;
  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept & w_grant_id;

  assign w_rsp_live = (r_state == ST_RESP);
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
  assign rsp0_valid = w_rsp_live & ~r_owner;
  assign rsp1_valid = w_rsp_live & r_owner;
  assign rsp0_data  = rsp0_valid ? r_result : '0;
  assign rsp1_data  = rsp1_valid ? r_result : '0;
  assign rsp0_err   = rsp0_valid & r_err;
  assign rsp1_err   = rsp1_valid & r_err;
  assign busy       = (r_state != ST_IDLE);

  bitcnt u_bitcnt (
    .i_data  (r_data),
    .i_func  (r_func),
    .o_count (w_count)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_take) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= 1'b1;
      r_owner  <= 1'b0;
      r_data   <= '0;
      r_func   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant_id;
        r_ptr   <= w_grant_id;
        r_data  <= w_grant_id ? req1_data : req0_data;
        r_func  <= w_grant_id ? req1_func : req0_func;
      end
      if (r_state == ST_EXEC) begin
        r_err    <= func_illegal(r_func);
        r_result <= func_illegal(r_func) ? '0 : {{(64-RES_W){1'b0}}, w_count};
      end
    end
  end

endmodule
